// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch/execute handshake and decoded-bundle bus for decode_queue
//
// Purpose: bundles the fetch-side request, the execute-side decoded bundle
// and the flush/sys_done controls into one port.
// Ports (slave = decoder side):
//   in_valid/in_ready/in_code/in_pc   fetch handshake
//   out_valid/out_ready + bundle      head of the decoded-bundle FIFO
//   flush, sys_done                   pipeline controls from execute
`ifndef DECODE_QUEUE_DEFS
`define DECODE_QUEUE_DEFS
`define ALU_OP_WIDTH    5
`define ALU_OP_NONE     5'd0
`define ALU_OP_ADD      5'd1
`define ALU_OP_SUB      5'd2
`define ALU_OP_SLL      5'd3
`define ALU_OP_SLT      5'd4
`define ALU_OP_SLTU     5'd5
`define ALU_OP_XOR      5'd6
`define ALU_OP_SRL      5'd7
`define ALU_OP_SRA      5'd8
`define ALU_OP_OR       5'd9
`define ALU_OP_AND      5'd10
`define ALU_OP_EQ       5'd11
`define ALU_OP_NE       5'd12
`define ALU_OP_LT       5'd13
`define ALU_OP_GE       5'd14
`define ALU_OP_LTU      5'd15
`define ALU_OP_GEU      5'd16
`define SEL_SRC_A_WIDTH 2
`define SEL_SRC_A_REG   2'd0
`define SEL_SRC_A_PC    2'd1
`define SEL_SRC_A_IMM   2'd2
`define SEL_SRC_B_WIDTH 2
`define SEL_SRC_B_REG   2'd0
`define SEL_SRC_B_IMM   2'd1
`define SEL_SRC_B_FOUR  2'd2
`define SEL_PC_WIDTH    3
`define SEL_PC_ADD4     3'd0
`define SEL_PC_JAL      3'd1
`define SEL_PC_JALR     3'd2
`define SEL_PC_MTVEC    3'd3
`define SEL_PC_MEPC     3'd4
`endif

interface decode_queue_if #(
  parameter int XLEN = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic [31:0]                 in_code;
  logic [XLEN-1:0]             in_pc;
  logic                        out_valid;
  logic                        out_ready;
  logic [XLEN-1:0]             out_pc;
  logic [4:0]                  rs1_num;
  logic [4:0]                  rs2_num;
  logic [4:0]                  rd_num;
  logic [XLEN-1:0]             imm;
  logic [`ALU_OP_WIDTH-1:0]    alu_op_sel;
  logic [`SEL_SRC_A_WIDTH-1:0] src_a_sel;
  logic [`SEL_SRC_B_WIDTH-1:0] src_b_sel;
  logic [`SEL_PC_WIDTH-1:0]    pc_sel;
  logic                        wb_reg;
  logic                        is_mext;
  logic [2:0]                  m_op;
  logic [2:0]                  csr_op;
  logic [11:0]                 csr_addr;
  logic                        illegal;
  logic                        flush;
  logic                        sys_done;

  modport master (
    output in_valid, in_code, in_pc, out_ready, flush, sys_done,
    input  in_ready, out_valid, out_pc, rs1_num, rs2_num, rd_num, imm,
           alu_op_sel, src_a_sel, src_b_sel, pc_sel, wb_reg, is_mext,
           m_op, csr_op, csr_addr, illegal
  );

  modport slave (
    input  in_valid, in_code, in_pc, out_ready, flush, sys_done,
    output in_ready, out_valid, out_pc, rs1_num, rs2_num, rd_num, imm,
           alu_op_sel, src_a_sel, src_b_sel, pc_sel, wb_reg, is_mext,
           m_op, csr_op, csr_addr, illegal
  );
endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - registered RV32I(+M) decoder with a DEPTH-entry bundle FIFO
//
// Purpose: decodes {code, pc} from fetch, queues decoded bundles for execute,
// flags illegal instructions and serialises SYSTEM/FENCE/illegal instructions.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    decode_queue_if.slave: fetch handshake, head bundle, flush, sys_done
`ifndef DECODE_QUEUE_DEFS
`define DECODE_QUEUE_DEFS
`define ALU_OP_WIDTH    5
`define ALU_OP_NONE     5'd0
`define ALU_OP_ADD      5'd1
`define ALU_OP_SUB      5'd2
`define ALU_OP_SLL      5'd3
`define ALU_OP_SLT      5'd4
`define ALU_OP_SLTU     5'd5
`define ALU_OP_XOR      5'd6
`define ALU_OP_SRL      5'd7
`define ALU_OP_SRA      5'd8
`define ALU_OP_OR       5'd9
`define ALU_OP_AND      5'd10
`define ALU_OP_EQ       5'd11
`define ALU_OP_NE       5'd12
`define ALU_OP_LT       5'd13
`define ALU_OP_GE       5'd14
`define ALU_OP_LTU      5'd15
`define ALU_OP_GEU      5'd16
`define SEL_SRC_A_WIDTH 2
`define SEL_SRC_A_REG   2'd0
`define SEL_SRC_A_PC    2'd1
`define SEL_SRC_A_IMM   2'd2
`define SEL_SRC_B_WIDTH 2
`define SEL_SRC_B_REG   2'd0
`define SEL_SRC_B_IMM   2'd1
`define SEL_SRC_B_FOUR  2'd2
`define SEL_PC_WIDTH    3
`define SEL_PC_ADD4     3'd0
`define SEL_PC_JAL      3'd1
`define SEL_PC_JALR     3'd2
`define SEL_PC_MTVEC    3'd3
`define SEL_PC_MEPC     3'd4
`endif

module decode_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int ENABLE_M = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  decode_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] CODE_ECALL = 32'h0000_0073;
  localparam logic [31:0] CODE_MRET  = 32'h3020_0073;

  typedef struct packed {
    logic [XLEN-1:0]             pc;
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic [4:0]                  rd;
    logic [XLEN-1:0]             imm;
    logic [`ALU_OP_WIDTH-1:0]    alu;
    logic [`SEL_SRC_A_WIDTH-1:0] src_a;
    logic [`SEL_SRC_B_WIDTH-1:0] src_b;
    logic [`SEL_PC_WIDTH-1:0]    pc_sel;
    logic                        wb;
    logic                        mext;
    logic [2:0]                  m_op;
    logic [2:0]                  csr_op;
    logic [11:0]                 csr_addr;
    logic                        illegal;
  } bundle_t;

  typedef enum logic {ST_RUN, ST_SERIAL} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------- decode (combinational on in_code) ----------------
  logic [31:0] code;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;
  logic        is_shift;
  bundle_t     dec;

  assign code   = bus.in_code;
  assign opcode = code[6:0];
  assign f3     = code[14:12];
  assign f7     = code[31:25];
  assign imm_i  = {{20{code[31]}}, code[31:20]};
  assign imm_s  = {{20{code[31]}}, code[31:25], code[11:7]};
  assign imm_b  = {{19{code[31]}}, code[31], code[7], code[30:25], code[11:8], 1'b0};
  assign imm_u  = {code[31:12], 12'b0};
  assign imm_j  = {{11{code[31]}}, code[31], code[19:12], code[20], code[30:21], 1'b0};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    bad = 1'b0;
    if (code[1:0] != 2'b11) bad = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE,
      OPC_MISC, OPC_SYSTEM: ;
      OPC_BRANCH: if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
      // func7 only exists for the shift forms; other OP-IMM top bits are immediate
      OPC_OPIMM: if (is_shift) begin
        if (f7 != 7'b0000000 && f7 != 7'b0100000) bad = 1'b1;
        if (f7 == 7'b0100000 && f3 != 3'b101) bad = 1'b1;
      end
      OPC_OP: begin
        if (f7 != 7'b0000000 && f7 != 7'b0100000 && f7 != 7'b0000001) bad = 1'b1;
        if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
        if (f7 == 7'b0000001 && ENABLE_M == 0) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.illegal = bad;
    if (!bad) begin
      case (opcode)
        OPC_LUI: begin
          // rs2 stays 0, so src_b reads x0 and the ALU passes the immediate
          dec.rd = code[11:7]; dec.imm = sext32(imm_u);
          dec.alu = `ALU_OP_ADD; dec.src_a = `SEL_SRC_A_IMM; dec.src_b = `SEL_SRC_B_REG;
          dec.wb = 1'b1;
        end
        OPC_AUIPC: begin
          dec.rd = code[11:7]; dec.imm = sext32(imm_u);
          dec.alu = `ALU_OP_ADD; dec.src_a = `SEL_SRC_A_PC; dec.src_b = `SEL_SRC_B_IMM;
          dec.wb = 1'b1;
        end
        OPC_JAL: begin
          dec.rd = code[11:7]; dec.imm = sext32(imm_j);
          dec.alu = `ALU_OP_ADD; dec.src_a = `SEL_SRC_A_PC; dec.src_b = `SEL_SRC_B_FOUR;
          dec.pc_sel = `SEL_PC_JAL; dec.wb = 1'b1;
        end
        OPC_JALR: begin
          dec.rd = code[11:7]; dec.rs1 = code[19:15]; dec.imm = sext32(imm_i);
          dec.alu = `ALU_OP_ADD; dec.src_a = `SEL_SRC_A_PC; dec.src_b = `SEL_SRC_B_FOUR;
          dec.pc_sel = `SEL_PC_JALR; dec.wb = 1'b1;
        end
        OPC_BRANCH: begin
          dec.rs1 = code[19:15]; dec.rs2 = code[24:20]; dec.imm = sext32(imm_b);
          case (f3)
            3'b000:  dec.alu = `ALU_OP_EQ;
            3'b001:  dec.alu = `ALU_OP_NE;
            3'b100:  dec.alu = `ALU_OP_LT;
            3'b101:  dec.alu = `ALU_OP_GE;
            3'b110:  dec.alu = `ALU_OP_LTU;
            default: dec.alu = `ALU_OP_GEU;
          endcase
        end
        OPC_LOAD: begin
          dec.rd = code[11:7]; dec.rs1 = code[19:15]; dec.imm = sext32(imm_i);
          dec.alu = `ALU_OP_ADD; dec.src_b = `SEL_SRC_B_IMM; dec.wb = 1'b1;
        end
        OPC_STORE: begin
          dec.rs1 = code[19:15]; dec.rs2 = code[24:20]; dec.imm = sext32(imm_s);
          dec.alu = `ALU_OP_ADD; dec.src_b = `SEL_SRC_B_IMM;
        end
        OPC_OPIMM, OPC_OP: begin
          dec.rd = code[11:7]; dec.rs1 = code[19:15]; dec.wb = 1'b1;
          if (opcode == OPC_OPIMM) begin
            dec.imm = sext32(imm_i); dec.src_b = `SEL_SRC_B_IMM;
          end else begin
            dec.rs2 = code[24:20];
          end
          if (opcode == OPC_OP && f7 == 7'b0000001) begin
            dec.mext = 1'b1; dec.m_op = f3;
          end else begin
            case (f3)
              3'b000:  dec.alu = (opcode == OPC_OP && f7[5]) ? `ALU_OP_SUB : `ALU_OP_ADD;
              3'b001:  dec.alu = `ALU_OP_SLL;
              3'b010:  dec.alu = `ALU_OP_SLT;
              3'b011:  dec.alu = `ALU_OP_SLTU;
              3'b100:  dec.alu = `ALU_OP_XOR;
              3'b101:  dec.alu = f7[5] ? `ALU_OP_SRA : `ALU_OP_SRL;
              3'b110:  dec.alu = `ALU_OP_OR;
              default: dec.alu = `ALU_OP_AND;
            endcase
          end
        end
        OPC_SYSTEM: begin
          dec.csr_addr = code[31:20];
          if (f3 != 3'b000) begin
            dec.csr_op = f3; dec.rd = code[11:7]; dec.rs1 = code[19:15]; dec.wb = 1'b1;
          end else if (code == CODE_ECALL) begin
            dec.pc_sel = `SEL_PC_MTVEC;
          end else if (code == CODE_MRET) begin
            dec.pc_sel = `SEL_PC_MEPC;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- FIFO + serialising FSM ----------------
  bundle_t           mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  state_t            state, state_nx;
  logic              enq, deq, serialising, in_ready;
  bundle_t           head;

  assign enq         = bus.in_valid && in_ready;
  assign deq         = bus.out_valid && bus.out_ready;
  assign serialising = dec.illegal || opcode == OPC_SYSTEM || opcode == OPC_MISC;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = ST_RUN;
    end else begin
      case (state)
        ST_RUN:    if (enq && serialising) state_nx = ST_SERIAL;
        ST_SERIAL: if (bus.sys_done) state_nx = ST_RUN;
        default:   state_nx = ST_RUN;
      endcase
    end
  end

  // rst_n gates in_ready so nothing is taken during the reset cycle
  always_comb begin
    in_ready = rst_n && (state == ST_RUN) && (count < CNT_W'(DEPTH)) && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (count != '0);
  assign bus.out_pc     = head.pc;
  assign bus.rs1_num    = head.rs1;
  assign bus.rs2_num    = head.rs2;
  assign bus.rd_num     = head.rd;
  assign bus.imm        = head.imm;
  assign bus.alu_op_sel = head.alu;
  assign bus.src_a_sel  = head.src_a;
  assign bus.src_b_sel  = head.src_b;
  assign bus.pc_sel     = head.pc_sel;
  assign bus.wb_reg     = head.wb;
  assign bus.is_mext    = head.mext;
  assign bus.m_op       = head.m_op;
  assign bus.csr_op     = head.csr_op;
  assign bus.csr_addr   = head.csr_addr;
  assign bus.illegal    = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue
`ifndef DECODE_QUEUE_DEFS
`define DECODE_QUEUE_DEFS
`define ALU_OP_WIDTH    5
`define ALU_OP_NONE     5'd0
`define ALU_OP_ADD      5'd1
`define ALU_OP_SUB      5'd2
`define ALU_OP_SLL      5'd3
`define ALU_OP_SLT      5'd4
`define ALU_OP_SLTU     5'd5
`define ALU_OP_XOR      5'd6
`define ALU_OP_SRL      5'd7
`define ALU_OP_SRA      5'd8
`define ALU_OP_OR       5'd9
`define ALU_OP_AND      5'd10
`define ALU_OP_EQ       5'd11
`define ALU_OP_NE       5'd12
`define ALU_OP_LT       5'd13
`define ALU_OP_GE       5'd14
`define ALU_OP_LTU      5'd15
`define ALU_OP_GEU      5'd16
`define SEL_SRC_A_WIDTH 2
`define SEL_SRC_A_REG   2'd0
`define SEL_SRC_A_PC    2'd1
`define SEL_SRC_A_IMM   2'd2
`define SEL_SRC_B_WIDTH 2
`define SEL_SRC_B_REG   2'd0
`define SEL_SRC_B_IMM   2'd1
`define SEL_SRC_B_FOUR  2'd2
`define SEL_PC_WIDTH    3
`define SEL_PC_ADD4     3'd0
`define SEL_PC_JAL      3'd1
`define SEL_PC_JALR     3'd2
`define SEL_PC_MTVEC    3'd3
`define SEL_PC_MEPC     3'd4
`endif

module tb_decode_queue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_queue_if #(.XLEN(32)) ifa ();
  decode_queue_if #(.XLEN(32)) ifm ();
  decode_queue_if #(.XLEN(64)) ifw ();

  decode_queue #(.XLEN(32), .DEPTH(2), .ENABLE_M(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  decode_queue #(.XLEN(32), .DEPTH(2), .ENABLE_M(1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
  decode_queue #(.XLEN(64), .DEPTH(2), .ENABLE_M(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [4:0]  alu;
    logic [1:0]  a, b;
    logic [2:0]  pcs;
    logic        wb, mext;
    logic [2:0]  mop, csrop;
    logic [11:0] csra;
    logic        ill;
    logic        full;
  } exp_t;

  typedef struct {
    logic [31:0] code;
    exp_t        e;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  exp_t sbq[$];
  exp_t cur_exp;
  vec_t sv[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] rs1, rs2, rd, input logic [63:0] imm,
                              input logic [4:0] alu, input logic [1:0] a, b,
                              input logic [2:0] pcs, input logic wb);
    exp_t e;
    e = '{pc: 64'h0, imm: imm, rs1: rs1, rs2: rs2, rd: rd, alu: alu, a: a, b: b, pcs: pcs,
          wb: wb, mext: 1'b0, mop: 3'd0, csrop: 3'd0, csra: 12'd0, ill: 1'b0, full: 1'b1};
    return e;
  endfunction

  function automatic exp_t mk_ill();
    exp_t e;
    e = mk(5'd0, 5'd0, 5'd0, 64'h0, `ALU_OP_NONE, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_ADD4, 1'b0);
    e.ill  = 1'b1;
    e.full = 1'b0;
    return e;
  endfunction

  task automatic cmp_a(input string t, input exp_t e);
    chk({t, ".pc"},      ifa.out_pc,     e.pc);
    chk({t, ".illegal"}, ifa.illegal,    e.ill);
    chk({t, ".alu"},     ifa.alu_op_sel, e.alu);
    chk({t, ".wb"},      ifa.wb_reg,     e.wb);
    chk({t, ".mext"},    ifa.is_mext,    e.mext);
    chk({t, ".pc_sel"},  ifa.pc_sel,     e.pcs);
    if (e.full) begin
      chk({t, ".rs1"},   ifa.rs1_num,   e.rs1);
      chk({t, ".rs2"},   ifa.rs2_num,   e.rs2);
      chk({t, ".rd"},    ifa.rd_num,    e.rd);
      chk({t, ".imm"},   ifa.imm,       e.imm);
      chk({t, ".src_a"}, ifa.src_a_sel, e.a);
      chk({t, ".src_b"}, ifa.src_b_sel, e.b);
      chk({t, ".m_op"},  ifa.m_op,      e.mop);
      chk({t, ".csr_op"},ifa.csr_op,    e.csrop);
      chk({t, ".csr_addr"}, ifa.csr_addr, e.csra);
    end
  endtask

  task automatic put(input logic [31:0] code, input logic [31:0] pc, input exp_t e);
    ifa.in_valid = 1'b1;
    ifa.in_code  = code;
    ifa.in_pc    = pc;
    cur_exp      = e;
    cur_exp.pc   = {32'h0, pc};
  endtask

  task automatic idle();
    ifa.in_valid = 1'b0;
  endtask

  // Scoreboard step: decide this cycle's dequeue/enqueue just before the edge.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst_n || ifa.flush) begin
      sbq.delete();
    end else begin
      if (ifa.out_valid && ifa.out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          cmp_a("head", e);
        end
      end
      if (ifa.in_valid && ifa.in_ready) sbq.push_back(cur_exp);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t ei;
    rst_n = 1'b0;
    ifa.in_valid = 0; ifa.in_code = 0; ifa.in_pc = 0; ifa.out_ready = 0; ifa.flush = 0; ifa.sys_done = 0;
    ifm.in_valid = 0; ifm.in_code = 0; ifm.in_pc = 0; ifm.out_ready = 1; ifm.flush = 0; ifm.sys_done = 0;
    ifw.in_valid = 0; ifw.in_code = 0; ifw.in_pc = 0; ifw.out_ready = 1; ifw.flush = 0; ifw.sys_done = 0;

    // reset
    ifa.in_valid = 1'b1; ifa.in_code = 32'h0050_0093;
    @(negedge clk); #1;
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_imm", ifa.imm, 0);
    chk("rst_rd", ifa.rd_num, 0);
    chk("rst_wb", ifa.wb_reg, 0);
    chk("rst_pc_sel", ifa.pc_sel, `SEL_PC_ADD4);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", ifa.in_ready, 1);

    // addi x1,x0,5 with latency check
    ifa.out_ready = 1'b1;
    put(32'h0050_0093, 32'h100, mk(0, 0, 1, 5, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    #1 chk("no_comb_path", ifa.out_valid, 0);
    tick();
    idle();
    #1 chk("latency_out_valid", ifa.out_valid, 1);
    tick();

    // assorted legal types, back to back
    put(32'h0020_8463, 32'h104, mk(1, 2, 0, 8, `ALU_OP_EQ, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_ADD4, 0));
    tick();
    put(32'hFE20_AE23, 32'h108, mk(1, 2, 0, 64'hFFFF_FFFC, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 0));
    tick();
    put(32'h0100_00EF, 32'h10C, mk(0, 0, 1, 16, `ALU_OP_ADD, `SEL_SRC_A_PC, `SEL_SRC_B_FOUR, `SEL_PC_JAL, 1));
    tick();
    put(32'h8000_02B7, 32'h110, mk(0, 0, 5, 64'h8000_0000, `ALU_OP_ADD, `SEL_SRC_A_IMM, `SEL_SRC_B_REG, `SEL_PC_ADD4, 1));
    tick();
    idle();
    tick();
    #1 chk("drain_out_valid", ifa.out_valid, 0);

    // fill DEPTH=2 with out_ready low
    ifa.out_ready = 1'b0;
    put(32'h0020_81B3, 32'h200, mk(1, 2, 3, 0, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_ADD4, 1));
    tick();
    put(32'h4011_8233, 32'h204, mk(3, 1, 4, 0, `ALU_OP_SUB, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_ADD4, 1));
    tick();
    put(32'hFFF0_C293, 32'h208, mk(1, 0, 5, 64'hFFFF_FFFF, `ALU_OP_XOR, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    #1 chk("full_in_ready", ifa.in_ready, 0);
    tick();
    ifa.out_ready = 1'b1;
    #1 chk("no_bypass_in_ready", ifa.in_ready, 0);
    tick();
    #1 chk("ready_after_deq", ifa.in_ready, 1);
    tick();
    idle();
    tick();
    #1 chk("fifo_empty", ifa.out_valid, 0);

    // ECALL serialises until sys_done
    ei = mk(0, 0, 0, 0, `ALU_OP_NONE, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_MTVEC, 0);
    put(32'h0000_0073, 32'h300, ei);
    tick();
    put(32'h0070_0113, 32'h304, mk(0, 0, 2, 7, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    #1 chk("ecall_serial_ready", ifa.in_ready, 0);
    tick();
    #1 chk("ecall_wait_ready", ifa.in_ready, 0);
    ifa.sys_done = 1'b1;
    #1 chk("ready_during_sys_done", ifa.in_ready, 0);
    tick();
    ifa.sys_done = 1'b0;
    #1 chk("ready_after_sys_done", ifa.in_ready, 1);
    tick();
    idle();
    tick();

    // serialising / illegal table
    ei = mk_ill(); sv.push_back('{32'h0220_8033, ei});
    ei = mk_ill(); sv.push_back('{32'h0050_0090, ei});
    ei = mk_ill(); sv.push_back('{32'h0020_A063, ei});
    ei = mk_ill(); sv.push_back('{32'h4010_9093, ei});
    ei = mk_ill(); sv.push_back('{32'h4011_C233, ei});
    ei = mk_ill(); sv.push_back('{32'h0000_001B, ei});
    ei = mk(0, 0, 0, 0, `ALU_OP_NONE, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_ADD4, 0);
    sv.push_back('{32'h0FF0_000F, ei});
    ei = mk(0, 0, 0, 0, `ALU_OP_NONE, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_MEPC, 0);
    ei.csra = 12'h302; sv.push_back('{32'h3020_0073, ei});
    ei = mk(0, 0, 1, 0, `ALU_OP_NONE, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_ADD4, 1);
    ei.csra = 12'h300; ei.csrop = 3'd2; sv.push_back('{32'h3000_20F3, ei});
    foreach (sv[i]) begin
      put(sv[i].code, 32'h400 + 32'(i * 4), sv[i].e);
      tick();
      idle();
      tick();
      #1 chk($sformatf("serial_%0d", i), ifa.in_ready, 0);
      ifa.sys_done = 1'b1;
      tick();
      ifa.sys_done = 1'b0;
      #1 chk($sformatf("resume_%0d", i), ifa.in_ready, 1);
    end

    // sys_done in RUN is ignored
    ifa.sys_done = 1'b1;
    tick();
    ifa.sys_done = 1'b0;
    #1 chk("sys_done_in_run", ifa.in_ready, 1);

    // flush overrides enqueue, dequeue and sys_done
    ifa.out_ready = 1'b0;
    put(32'h0010_0093, 32'h500, mk(0, 0, 1, 1, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    tick();
    put(32'h0020_0093, 32'h504, mk(0, 0, 1, 2, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    tick();
    put(32'h0030_0093, 32'h508, mk(0, 0, 1, 3, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    ifa.flush = 1'b1; ifa.sys_done = 1'b1; ifa.out_ready = 1'b1;
    #1 chk("flush_in_ready", ifa.in_ready, 0);
    tick();
    ifa.flush = 1'b0; ifa.sys_done = 1'b0; idle();
    #1 chk("flush_out_valid", ifa.out_valid, 0);
    chk("flush_ready_run", ifa.in_ready, 1);
    ifa.out_ready = 1'b0;
    put(32'h0070_0113, 32'h50C, mk(0, 0, 2, 7, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    tick();
    put(32'h0050_0093, 32'h510, mk(0, 0, 1, 5, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    #1 chk("flush_count_zero", ifa.in_ready, 1);
    tick();
    idle();
    #1 chk("refill_full", ifa.in_ready, 0);
    ifa.out_ready = 1'b1;
    tick();
    tick();
    #1 chk("refill_drained", ifa.out_valid, 0);

    // flush leaves SERIAL
    put(32'h0000_0073, 32'h600, mk(0, 0, 0, 0, `ALU_OP_NONE, `SEL_SRC_A_REG, `SEL_SRC_B_REG, `SEL_PC_MTVEC, 0));
    tick();
    idle();
    ifa.flush = 1'b1;
    tick();
    ifa.flush = 1'b0;
    #1 chk("flush_serial_ready", ifa.in_ready, 1);
    chk("flush_serial_out_valid", ifa.out_valid, 0);

    // reset mid-operation
    ifa.out_ready = 1'b0;
    put(32'h0070_0113, 32'h700, mk(0, 0, 2, 7, `ALU_OP_ADD, `SEL_SRC_A_REG, `SEL_SRC_B_IMM, `SEL_PC_ADD4, 1));
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 chk("midrst_out_valid", ifa.out_valid, 0);
    chk("midrst_imm", ifa.imm, 0);
    chk("midrst_rd", ifa.rd_num, 0);
    chk("midrst_in_ready", ifa.in_ready, 1);
    chk("sb_empty", sbq.size(), 0);

    // ENABLE_M=1 instance
    ifm.in_valid = 1'b1; ifm.in_code = 32'h0220_8033; ifm.in_pc = 32'h800;
    @(negedge clk);
    ifm.in_valid = 1'b0;
    #1;
    chk("m_valid", ifm.out_valid, 1);
    chk("m_is_mext", ifm.is_mext, 1);
    chk("m_m_op", ifm.m_op, 0);
    chk("m_wb", ifm.wb_reg, 1);
    chk("m_illegal", ifm.illegal, 0);
    chk("m_rs1", ifm.rs1_num, 1);
    chk("m_rs2", ifm.rs2_num, 2);
    @(negedge clk);
    ifm.in_valid = 1'b1; ifm.in_code = 32'h0220_D1B3; ifm.in_pc = 32'h804;
    @(negedge clk);
    ifm.in_valid = 1'b0;
    #1;
    chk("divu_m_op", ifm.m_op, 5);
    chk("divu_rd", ifm.rd_num, 3);
    chk("divu_mext", ifm.is_mext, 1);
    chk("divu_pc", ifm.out_pc, 32'h804);
    @(negedge clk);

    // XLEN=64 instance
    ifw.in_valid = 1'b1; ifw.in_code = 32'h8000_02B7; ifw.in_pc = 64'hFFFF_FFFF_8000_0000;
    @(negedge clk);
    ifw.in_valid = 1'b0;
    #1;
    chk("w_imm", ifw.imm, 64'hFFFF_FFFF_8000_0000);
    chk("w_rd", ifw.rd_num, 5);
    chk("w_src_a", ifw.src_a_sel, `SEL_SRC_A_IMM);
    chk("w_pc", ifw.out_pc, 64'hFFFF_FFFF_8000_0000);
    @(negedge clk);
    ifw.in_valid = 1'b1; ifw.in_code = 32'hFFF0_0093; ifw.in_pc = 64'h1000;
    @(negedge clk);
    ifw.in_valid = 1'b0;
    #1;
    chk("w_neg_imm", ifw.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    ifw.in_valid = 1'b1; ifw.in_code = 32'h0000_001B;
    @(negedge clk);
    ifw.in_valid = 1'b0;
    #1 chk("w_addiw_illegal", ifw.illegal, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
